// File: rtl/regalu_sequencer.sv
// regalu_sequencer: multi-cycle controller for the RegArray + ALU datapath.
// Takes one register-register command per handshake and steps it through
// read-register (RR), execute/flag capture (F) and write-back (WB), driving
// single-cycle phase enables, register addresses and the ALU opcode.
module regalu_sequencer #(
  parameter int CNT_W      = 16,
  parameter int ZERO_GUARD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_ra,
  input  logic [4:0]       cmd_rb,
  input  logic [4:0]       cmd_rd,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_we,
  output logic [4:0]       R_Addr_A,
  output logic [4:0]       R_Addr_B,
  output logic [4:0]       W_Addr,
  output logic [3:0]       ALU_OP,
  output logic             rr_en,
  output logic             f_en,
  output logic             wb_en,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RR   = 3'd1,
    S_F    = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  logic   we_l;

  // Write-back is taken only for writing commands; register 0 is optionally
  // protected so it can serve as a hard-wired zero source.
  function automatic logic wb_needed(input logic we, input logic [4:0] rd);
    logic guard_hit;
    guard_hit = (ZERO_GUARD != 0) && (rd == 5'd0);
    return we && !guard_hit;
  endfunction

  // Handshake and busy follow the registered state directly.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Phase sequencer: state, latched command fields, registered strobes,
  // flag capture and the retired-command counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      we_l      <= 1'b0;
      R_Addr_A  <= 5'd0;
      R_Addr_B  <= 5'd0;
      W_Addr    <= 5'd0;
      ALU_OP    <= 4'd0;
      rr_en     <= 1'b0;
      f_en      <= 1'b0;
      wb_en     <= 1'b0;
      done      <= 1'b0;
      flags     <= 4'd0;
      instr_cnt <= '0;
    end else begin
      // Strobes are single-cycle: cleared unless the next state asserts one.
      rr_en <= 1'b0;
      f_en  <= 1'b0;
      wb_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            R_Addr_A <= cmd_ra;
            R_Addr_B <= cmd_rb;
            W_Addr   <= cmd_rd;
            ALU_OP   <= cmd_op;
            we_l     <= cmd_we;
            rr_en    <= 1'b1;
            state    <= S_RR;
          end
        end
        S_RR: begin
          f_en  <= 1'b1;
          state <= S_F;
        end
        S_F: begin
          flags <= alu_flags;
          if (wb_needed(we_l, W_Addr)) begin
            wb_en <= 1'b1;
            state <= S_WB;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_WB: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          instr_cnt <= instr_cnt + CNT_W'(1);
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regalu_sequencer.sv
// Scoreboard bench for regalu_sequencer: stimulus pushes expected retirements,
// a negedge monitor pops them at accept and checks strobe timing, addresses,
// flags and the retired count as the DUT presents them.
module tb_regalu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_valid_nz;
  logic [4:0] cmd_ra, cmd_rb, cmd_rd;
  logic [3:0] cmd_op;
  logic       cmd_we;
  logic [3:0] alu_flags;

  logic       cmd_ready, rr_en, f_en, wb_en, done, busy;
  logic [4:0] R_Addr_A, R_Addr_B, W_Addr;
  logic [3:0] ALU_OP, flags;
  logic [3:0] instr_cnt;

  logic        cmd_ready_nz, rr_en_nz, f_en_nz, wb_en_nz, done_nz, busy_nz;
  logic [4:0]  R_Addr_A_nz, R_Addr_B_nz, W_Addr_nz;
  logic [3:0]  ALU_OP_nz, flags_nz;
  logic [15:0] instr_cnt_nz;

  always #5 clk = ~clk;

  regalu_sequencer #(.CNT_W(4), .ZERO_GUARD(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_op(cmd_op),
    .cmd_we(cmd_we), .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .W_Addr(W_Addr), .ALU_OP(ALU_OP), .rr_en(rr_en), .f_en(f_en),
    .wb_en(wb_en), .alu_flags(alu_flags), .flags(flags), .done(done),
    .busy(busy), .instr_cnt(instr_cnt)
  );

  regalu_sequencer #(.CNT_W(16), .ZERO_GUARD(0)) dut_nz (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_nz), .cmd_ready(cmd_ready_nz),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_op(cmd_op),
    .cmd_we(cmd_we), .R_Addr_A(R_Addr_A_nz), .R_Addr_B(R_Addr_B_nz),
    .W_Addr(W_Addr_nz), .ALU_OP(ALU_OP_nz), .rr_en(rr_en_nz), .f_en(f_en_nz),
    .wb_en(wb_en_nz), .alu_flags(alu_flags), .flags(flags_nz), .done(done_nz),
    .busy(busy_nz), .instr_cnt(instr_cnt_nz)
  );

  typedef struct {
    logic [4:0] ra, rb, rd;
    logic [3:0] op;
    logic       wb;
    logic [3:0] fl;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   inflight = 0;
  bit   wb_seen = 0;
  int   n_ret = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_addrs(input string ph);
    chk({ph, "_ra"}, 32'(R_Addr_A), 32'(cur.ra));
    chk({ph, "_rb"}, 32'(R_Addr_B), 32'(cur.rb));
    chk({ph, "_rd"}, 32'(W_Addr), 32'(cur.rd));
    chk({ph, "_op"}, 32'(ALU_OP), 32'(cur.op));
  endtask

  // Monitor: samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
      wb_seen  = 0;
    end else begin
      chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
      chk("strobe_onehot", 32'((int'(rr_en) + int'(f_en) + int'(wb_en) + int'(done)) <= 1), 32'd1);
      if (rr_en) begin
        if (!inflight) chk("rr_unexpected", 32'd1, 32'd0);
        else begin
          chk("rr_latency", 32'(cyc - acc_cyc), 32'd1);
          chk_addrs("rr");
        end
      end
      if (f_en) begin
        if (!inflight) chk("f_unexpected", 32'd1, 32'd0);
        else begin
          chk("f_latency", 32'(cyc - acc_cyc), 32'd2);
          chk_addrs("f");
        end
      end
      if (wb_en) begin
        if (!inflight) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          wb_seen = 1;
          chk("wb_allowed", 32'(cur.wb), 32'd1);
          chk("wb_latency", 32'(cyc - acc_cyc), 32'd3);
          chk_addrs("wb");
        end
      end
      if (done) begin
        if (!inflight) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          chk("done_latency", 32'(cyc - acc_cyc), cur.wb ? 32'd4 : 32'd3);
          chk("done_wb_seen", 32'(wb_seen), 32'(cur.wb));
          chk("done_flags", 32'(flags), 32'(cur.fl));
          chk("done_cnt_before", 32'(instr_cnt), 32'(cur.cnt));
          chk_addrs("done");
          inflight = 0;
          wb_seen  = 0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
        else begin
          cur      = sb.pop_front();
          acc_cyc  = cyc;
          inflight = 1;
          wb_seen  = 0;
        end
      end
    end
  end

  task automatic push_exp(input logic [4:0] ra, rb, rd, input logic [3:0] op,
                          input logic we, input logic [3:0] fl);
    exp_t e;
    e.ra = ra; e.rb = rb; e.rd = rd; e.op = op; e.fl = fl;
    e.wb  = we && (rd != 5'd0);
    e.cnt = 4'(n_ret);
    n_ret++;
    sb.push_back(e);
  endtask

  task automatic wait_accept(output int a);
    bit got;
    got = 0;
    a   = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        a   = cyc;
        got = 1;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [4:0] ra, rb, rd, input logic [3:0] op,
                       input logic we, input logic [3:0] fl);
    int a;
    cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_op = op; cmd_we = we;
    alu_flags = fl;
    push_exp(ra, rb, rd, op, we, fl);
    cmd_valid = 1'b1;
    wait_accept(a);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_strobes"}, 32'({rr_en, f_en, wb_en, done}), 32'd0);
    chk({nm, "_addrs"}, 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'd0);
    chk({nm, "_flags"}, 32'(flags), 32'd0);
    chk({nm, "_cnt"}, 32'(instr_cnt), 32'd0);
    @(posedge clk); #2;
  endtask

  initial begin
    int a0, a1, a2;
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid_nz = 1'b0;
    cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_op = '0; cmd_we = 1'b0;
    alu_flags = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk_reset_state("init");

    // Single writing command; fields toggled while busy must not leak.
    issue(5'd1, 5'd2, 5'd3, 4'h2, 1'b1, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      cmd_ra = 5'(i + 9); cmd_rb = 5'(i + 17); cmd_rd = 5'(i + 25); cmd_op = 4'(i + 7);
      cmd_we = 1'b0;
      @(posedge clk); #2;
    end
    wait_idle();
    @(negedge clk);
    chk("t2_cnt", 32'(instr_cnt), 32'd1);
    chk("t2_flags_idle", 32'(flags), 32'h8);
    chk("t2_addr_hold", 32'({R_Addr_A, R_Addr_B, W_Addr, ALU_OP}), 32'({5'd1, 5'd2, 5'd3, 4'h2}));
    @(posedge clk); #2;

    // Reset held two cycles from the F phase aborts the command.
    issue(5'd4, 5'd6, 5'd5, 4'h9, 1'b1, 4'b0110);
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n_ret = 0;
    chk_reset_state("abort");
    repeat (6) @(posedge clk);
    #2;

    // Write-back suppressed: we=0, and rd=0 with the zero guard.
    issue(5'd7, 5'd8, 5'd9, 4'h5, 1'b0, 4'b0001);
    wait_idle();
    issue(5'd10, 5'd11, 5'd0, 4'h3, 1'b1, 4'b0010);
    wait_idle();

    // Guard disabled: rd=0 with we=1 writes back at c3.
    cmd_ra = 5'd2; cmd_rb = 5'd3; cmd_rd = 5'd0; cmd_op = 4'hA; cmd_we = 1'b1;
    alu_flags = 4'b0100;
    cmd_valid_nz = 1'b1;
    @(negedge clk);
    chk("nz_ready", 32'(cmd_ready_nz), 32'd1);
    @(posedge clk); #2;
    cmd_valid_nz = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("nz_wb_c%0d", k), 32'(wb_en_nz), 32'(k == 3));
      chk($sformatf("nz_done_c%0d", k), 32'(done_nz), 32'(k == 4));
      if (k == 3) chk("nz_waddr", 32'(W_Addr_nz), 32'd0);
    end
    @(posedge clk); #2;

    // cmd_valid held high across three commands.
    alu_flags = 4'b1010;
    cmd_ra = 5'd12; cmd_rb = 5'd13; cmd_rd = 5'd14; cmd_op = 4'h1; cmd_we = 1'b1;
    push_exp(5'd12, 5'd13, 5'd14, 4'h1, 1'b1, 4'b1010);
    cmd_valid = 1'b1;
    wait_accept(a0);
    cmd_ra = 5'd15; cmd_rb = 5'd16; cmd_rd = 5'd17; cmd_op = 4'h6; cmd_we = 1'b1;
    push_exp(5'd15, 5'd16, 5'd17, 4'h6, 1'b1, 4'b1010);
    wait_accept(a1);
    cmd_ra = 5'd18; cmd_rb = 5'd19; cmd_rd = 5'd20; cmd_op = 4'hF; cmd_we = 1'b1;
    push_exp(5'd18, 5'd19, 5'd20, 4'hF, 1'b1, 4'b1010);
    wait_accept(a2);
    cmd_valid = 1'b0;
    chk("held_space1", 32'(a1 - a0), 32'd5);
    chk("held_space2", 32'(a2 - a1), 32'd5);
    wait_idle();

    // Counter wrap with a 4-bit counter: 17 commands from zero.
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    n_ret = 0;
    for (int n = 1; n <= 17; n++) begin
      issue(5'(n), 5'(n + 1), 5'(n + 2), 4'(n), n[0], 4'(n));
      wait_idle();
      @(negedge clk);
      if (n == 15) chk("wrap_15", 32'(instr_cnt), 32'd15);
      if (n == 16) chk("wrap_0", 32'(instr_cnt), 32'd0);
      if (n == 17) chk("wrap_1", 32'(instr_cnt), 32'd1);
      @(posedge clk); #2;
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("none_inflight", 32'(inflight), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
